axi_burst_mem_slave: RTL and testbench

AXI responder that serves INCR-style burst reads and writes from an internal word-addressed memory. It sits at the far end of the AXI link driven by the cache-line bulk adapter and stands in for DRAM in simulation and small FPGA builds. Read and write channels run independently. The read side can insert programmable wait states so that master stall handling is exercised.

---
 rtl/axi_pkg.sv | 16 +
 rtl/axi_interface_if.sv | 57 +++++
 rtl/strobed_word_ram.sv | 30 +++
 rtl/axi_burst_mem_slave.sv | 193 +++++++++++++++++++
 tb/tb_axi_burst_mem_slave.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings: response codes and burst types.
package axi_pkg;

  typedef logic [1:0] axi_resp_t;
  typedef logic [1:0] axi_burst_t;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_EXOKAY = 2'b01;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
  localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

  localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
  localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
  localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;

endpackage

// File: rtl/axi_interface_if.sv
// AXI bundle split into read (AR/R) and write (AW/W/B) channel modports.
// Slave modports: rd_slv, wr_slv. Master modports: rd_mst, wr_mst.
interface axi_interface_if
  import axi_pkg::*;
#(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 8
) ();

  // read address / data
  logic              arvalid, arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  axi_burst_t        arburst;
  logic [2:0]        arsize;
  logic              rvalid, rready, rlast;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  axi_resp_t         rresp;

  // write address / data / response
  logic                awvalid, awready;
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [LEN_W-1:0]    awlen;
  axi_burst_t          awburst;
  logic [2:0]          awsize;
  logic                wvalid, wready, wlast;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                bvalid, bready;
  logic [ID_W-1:0]     bid;
  axi_resp_t           bresp;

  modport rd_slv (
    input  arvalid, arid, araddr, arlen, arburst, arsize, rready,
    output arready, rvalid, rdata, rid, rresp, rlast
  );
  modport wr_slv (
    input  awvalid, awid, awaddr, awlen, awburst, awsize,
           wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bid, bresp
  );
  modport rd_mst (
    output arvalid, arid, araddr, arlen, arburst, arsize, rready,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );
  modport wr_mst (
    output awvalid, awid, awaddr, awlen, awburst, awsize,
           wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bid, bresp
  );

endinterface

// File: rtl/strobed_word_ram.sv
// Word-addressed storage: combinational read port, byte-strobed synchronous
// write port. Contents are never reset.
// Ports: clk, rd_idx -> rd_data, we/wr_idx/wstrb/wdata.
module strobed_word_ram #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS),
  localparam int unsigned STRB_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Read sees pre-write contents in a same-word collision.
  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (we && wstrb[b]) mem[wr_idx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI memory responder serving incrementing full-width bursts from an internal
// RAM. Independent read and write FSMs, one outstanding transaction each;
// RD_WAIT idle cycles precede the first read beat.
// Ports: clk, rst (sync, active high), axi_read_in (AR/R), axi_write_in (AW/W/B).
module axi_burst_mem_slave
  import axi_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_WAIT     = 0
) (
  input  logic           clk,
  input  logic           rst,
  axi_interface_if.rd_slv axi_read_in,
  axi_interface_if.wr_slv axi_write_in
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ID_W   = $bits(axi_read_in.arid);
  localparam int unsigned LEN_W  = $bits(axi_read_in.arlen);
  localparam int unsigned WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  r_state_t           r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [LEN_W-1:0]   r_left;
  logic [ID_W-1:0]    r_id;
  logic [WAIT_W-1:0]  r_wait;

  w_state_t           w_state;
  logic [IDX_W-1:0]   w_idx;
  logic [LEN_W-1:0]   w_left;
  logic [ID_W-1:0]    w_id;

  logic [IDX_W-1:0]   ar_idx_c;
  logic [IDX_W-1:0]   aw_idx_c;
  logic [IDX_W-1:0]   rd_idx_c;
  logic [DATA_W-1:0]  rd_data_c;
  logic               we_c;

  assign ar_idx_c = IDX_W'(axi_read_in.araddr >> OFF_W);
  assign aw_idx_c = IDX_W'(axi_write_in.awaddr >> OFF_W);
  assign we_c     = (w_state == W_DATA) && axi_write_in.wvalid && axi_write_in.wready;

  // Read port looks at the word that the next registered beat will carry.
  always_comb begin
    rd_idx_c = r_idx;
    if (r_state == R_IDLE)      rd_idx_c = ar_idx_c;
    else if (r_state == R_DATA) rd_idx_c = r_idx + IDX_W'(1);
  end

  strobed_word_ram #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .rd_idx  (rd_idx_c),
    .rd_data (rd_data_c),
    .we      (we_c),
    .wr_idx  (w_idx),
    .wstrb   (axi_write_in.wstrb),
    .wdata   (axi_write_in.wdata)
  );

  // Read FSM with registered R channel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state             <= R_IDLE;
      r_idx               <= '0;
      r_left              <= '0;
      r_id                <= '0;
      r_wait              <= '0;
      axi_read_in.arready <= 1'b0;
      axi_read_in.rvalid  <= 1'b0;
      axi_read_in.rdata   <= '0;
      axi_read_in.rid     <= '0;
      axi_read_in.rresp   <= AXI_RESP_OKAY;
      axi_read_in.rlast   <= 1'b0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          axi_read_in.arready <= 1'b1;
          if (axi_read_in.arvalid && axi_read_in.arready) begin
            axi_read_in.arready <= 1'b0;
            r_id   <= axi_read_in.arid;
            r_idx  <= ar_idx_c;
            r_left <= axi_read_in.arlen;
            if (RD_WAIT > 0) begin
              r_state <= R_WAIT;
              r_wait  <= WAIT_W'(RD_WAIT - 1);
            end else begin
              r_state             <= R_DATA;
              axi_read_in.rvalid  <= 1'b1;
              axi_read_in.rdata   <= rd_data_c;
              axi_read_in.rid     <= axi_read_in.arid;
              axi_read_in.rresp   <= AXI_RESP_OKAY;
              axi_read_in.rlast   <= (axi_read_in.arlen == '0);
            end
          end
        end
        R_WAIT: begin
          if (r_wait == '0) begin
            r_state             <= R_DATA;
            axi_read_in.rvalid  <= 1'b1;
            axi_read_in.rdata   <= rd_data_c;
            axi_read_in.rid     <= r_id;
            axi_read_in.rresp   <= AXI_RESP_OKAY;
            axi_read_in.rlast   <= (r_left == '0);
          end else begin
            r_wait <= r_wait - WAIT_W'(1);
          end
        end
        R_DATA: begin
          if (axi_read_in.rready) begin
            if (r_left == '0) begin
              r_state             <= R_IDLE;
              axi_read_in.arready <= 1'b1;
              axi_read_in.rvalid  <= 1'b0;
              axi_read_in.rdata   <= '0;
              axi_read_in.rid     <= '0;
              axi_read_in.rresp   <= AXI_RESP_OKAY;
              axi_read_in.rlast   <= 1'b0;
            end else begin
              r_idx             <= r_idx + IDX_W'(1);
              r_left            <= r_left - LEN_W'(1);
              axi_read_in.rdata <= rd_data_c;
              axi_read_in.rlast <= (r_left == LEN_W'(1));
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM with registered handshake/response outputs; beat count from awlen.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state              <= W_IDLE;
      w_idx                <= '0;
      w_left               <= '0;
      w_id                 <= '0;
      axi_write_in.awready <= 1'b0;
      axi_write_in.wready  <= 1'b0;
      axi_write_in.bvalid  <= 1'b0;
      axi_write_in.bid     <= '0;
      axi_write_in.bresp   <= AXI_RESP_OKAY;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          axi_write_in.awready <= 1'b1;
          if (axi_write_in.awvalid && axi_write_in.awready) begin
            axi_write_in.awready <= 1'b0;
            axi_write_in.wready  <= 1'b1;
            w_id    <= axi_write_in.awid;
            w_idx   <= aw_idx_c;
            w_left  <= axi_write_in.awlen;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (we_c) begin
            w_idx <= w_idx + IDX_W'(1);
            if (w_left == '0) begin
              w_state             <= W_RESP;
              axi_write_in.wready <= 1'b0;
              axi_write_in.bvalid <= 1'b1;
              axi_write_in.bid    <= w_id;
              axi_write_in.bresp  <= AXI_RESP_OKAY;
            end else begin
              w_left <= w_left - LEN_W'(1);
            end
          end
        end
        W_RESP: begin
          if (axi_write_in.bready) begin
            w_state              <= W_IDLE;
            axi_write_in.bvalid  <= 1'b0;
            axi_write_in.bid     <= '0;
            axi_write_in.bresp   <= AXI_RESP_OKAY;
            axi_write_in.awready <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Bench for axi_burst_mem_slave: directed and randomized bursts checked against
// a byte-level memory model held as a plain array.
module tb_axi_burst_mem_slave;

  localparam int DEPTH = 16;
  localparam int WAITS = 3;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  logic [63:0] model [DEPTH];
  logic [7:0]  vm    [DEPTH];
  logic [63:0] wbuf  [8];
  logic [7:0]  sbuf  [8];

  axi_interface_if #(.ID_W(4), .ADDR_W(32), .DATA_W(64), .LEN_W(8)) bus ();

  axi_burst_mem_slave #(
    .DATA_W      (64),
    .DEPTH_WORDS (DEPTH),
    .RD_WAIT     (WAITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .axi_read_in  (bus),
    .axi_write_in (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bytemask(input logic [7:0] v);
    logic [63:0] m;
    for (int k = 0; k < 8; k++) m[k*8 +: 8] = {8{v[k]}};
    return m;
  endfunction

  function automatic int widx(input logic [31:0] addr, input int beat);
    return (int'(addr >> 3) + beat) % DEPTH;
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input bit gaps, input int bstall);
    int n;
    int w;
    @(negedge clk);
    bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
    bus.wvalid = 1'b1; bus.wdata = wbuf[0]; bus.wstrb = sbuf[0];
    bus.bready = (bstall == 0);
    n = 0;
    while (!bus.awready && n < 100) begin @(negedge clk); n++; end
    chk("aw_ready", 64'(bus.awready), 64'd1);
    chk("wready_before_aw", 64'(bus.wready), 64'd0);
    @(negedge clk);
    bus.awvalid = 1'b0;
    chk("wready_after_aw", 64'(bus.wready), 64'd1);
    for (int b = 0; b <= len; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.wvalid = 1'b0;
        @(negedge clk);
      end
      bus.wvalid = 1'b1; bus.wdata = wbuf[b]; bus.wstrb = sbuf[b];
      n = 0;
      while (!bus.wready && n < 100) begin @(negedge clk); n++; end
      w = widx(addr, b);
      for (int k = 0; k < 8; k++)
        if (sbuf[b][k]) model[w][k*8 +: 8] = wbuf[b][k*8 +: 8];
      vm[w] = vm[w] | sbuf[b];
      @(negedge clk);
    end
    bus.wvalid = 1'b0;
    chk("bvalid_after_last_w", 64'(bus.bvalid), 64'd1);
    chk("bid", 64'(bus.bid), 64'(id));
    chk("bresp", 64'(bus.bresp), 64'd0);
    chk("wready_in_resp", 64'(bus.wready), 64'd0);
    for (int d = 0; d < bstall; d++) begin
      @(negedge clk);
      chk("bvalid_stall", 64'(bus.bvalid), 64'd1);
      chk("awready_stall", 64'(bus.awready), 64'd0);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    chk("bvalid_cleared", 64'(bus.bvalid), 64'd0);
    chk("bid_cleared", 64'(bus.bid), 64'd0);
    chk("awready_after_b", 64'(bus.awready), 64'd1);
  endtask

  // mode 0: rready held high, 1: toggling, 2: random. abort_at>0 resets mid-burst.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int mode, input int abort_at);
    int n;
    int acc;
    int b;
    bit first;
    bit hold;
    bit tg;
    bit rr;
    logic [63:0] held;
    logic [63:0] m;
    int w;
    @(negedge clk);
    bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len);
    bus.rready = 1'b0;
    n = 0;
    while (!bus.arready && n < 100) begin @(negedge clk); n++; end
    chk("ar_ready", 64'(bus.arready), 64'd1);
    acc = cyc + 1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    b = 0; n = 0; first = 1'b1; hold = 1'b0; tg = 1'b1; held = '0;
    while (b <= len && n < 300) begin
      if (bus.rvalid) begin
        if (first) begin
          chk("r_first_latency", 64'(cyc), 64'(acc + WAITS));
          first = 1'b0;
        end
        if (hold) chk("r_hold_stable", bus.rdata, held);
        if (abort_at > 0 && b == abort_at) begin
          rst = 1'b1; bus.rready = 1'b0;
          @(negedge clk);
          chk("rvalid_after_rst", 64'(bus.rvalid), 64'd0);
          chk("arready_in_rst", 64'(bus.arready), 64'd0);
          rst = 1'b0;
          @(negedge clk);
          chk("arready_after_rst", 64'(bus.arready), 64'd1);
          chk("rvalid_after_rst2", 64'(bus.rvalid), 64'd0);
          return;
        end
        w = widx(addr, b);
        m = bytemask(vm[w]);
        chk("rdata", bus.rdata & m, model[w] & m);
        chk("rid", 64'(bus.rid), 64'(id));
        chk("rlast", 64'(bus.rlast), 64'(b == len));
        chk("rresp", 64'(bus.rresp), 64'd0);
        chk("arready_busy", 64'(bus.arready), 64'd0);
        rr = (mode == 0) ? 1'b1 : (mode == 1) ? tg : 1'($urandom_range(0, 1));
        tg = ~tg;
        bus.rready = rr;
        if (rr) begin b++; hold = 1'b0; end
        else begin hold = 1'b1; held = bus.rdata; end
      end else begin
        chk("rdata_idle_zero", bus.rdata, 64'd0);
        chk("arready_wait", 64'(bus.arready), 64'd0);
        bus.rready = (mode == 0);
      end
      @(negedge clk);
      n++;
    end
    bus.rready = 1'b0;
    chk("r_beats", 64'(b), 64'(len + 1));
    chk("rvalid_done", 64'(bus.rvalid), 64'd0);
    chk("rlast_done", 64'(bus.rlast), 64'd0);
    chk("arready_return", 64'(bus.arready), 64'd1);
  endtask

  initial begin
    logic [31:0] ra;
    int rl;
    total = 0; bad = 0; cyc = 0;
    for (int i = 0; i < DEPTH; i++) begin model[i] = '0; vm[i] = '0; end
    rst = 1'b1;
    bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
    bus.arburst = 2'b01; bus.arsize = 3'd3; bus.rready = 1'b0;
    bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0;
    bus.awburst = 2'b01; bus.awsize = 3'd3;
    bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.bready = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_arready", 64'(bus.arready), 64'd0);
    chk("rst_awready", 64'(bus.awready), 64'd0);
    chk("rst_wready", 64'(bus.wready), 64'd0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
    chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
    chk("rst_rlast", 64'(bus.rlast), 64'd0);
    chk("rst_rdata", bus.rdata, 64'd0);
    chk("rst_rid", 64'(bus.rid), 64'd0);
    chk("rst_bid", 64'(bus.bid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("arready_out_of_rst", 64'(bus.arready), 64'd1);
    chk("awready_out_of_rst", 64'(bus.awready), 64'd1);

    // write then read 8 beats
    for (int i = 0; i < 8; i++) begin wbuf[i] = 64'h1000 + 64'(i); sbuf[i] = 8'hFF; end
    do_write(4'd1, 32'h40, 7, 1'b0, 0);
    do_read(4'd2, 32'h40, 7, 0, 0);

    // partial strobe
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'hFF;
    do_write(4'd3, 32'h80, 0, 1'b0, 0);
    wbuf[0] = 64'h0; sbuf[0] = 8'h0F;
    do_write(4'd3, 32'h80, 0, 1'b0, 0);
    chk("partial_model", model[widx(32'h80, 0)], 64'hFFFF_FFFF_0000_0000);
    do_read(4'd4, 32'h80, 0, 0, 0);

    // read backpressure with toggling rready
    do_read(4'd5, 32'h40, 7, 1, 0);

    // address wrap: words 14,15,0,1
    for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    do_write(4'd6, 32'h70, 3, 1'b1, 0);
    do_read(4'd7, 32'h70, 3, 2, 0);

    // concurrent read of words 2..5 and write of words 7..10, with B stall
    for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    do_write(4'd8, 32'h10, 3, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    fork
      do_read(4'd9, 32'h10, 3, 2, 0);
      do_write(4'd10, 32'h38, 3, 1'b1, 5);
    join
    do_read(4'd11, 32'h38, 3, 0, 0);

    // reset in the middle of a burst, then data still intact
    do_read(4'd12, 32'h40, 7, 0, 3);
    do_read(4'd13, 32'h40, 7, 0, 0);

    // randomized bursts, unaligned addresses allowed
    for (int t = 0; t < 8; t++) begin
      ra = $urandom & 32'hFF;
      rl = $urandom_range(0, 7);
      for (int i = 0; i < 8; i++) begin
        wbuf[i] = {$urandom, $urandom};
        sbuf[i] = 8'($urandom);
      end
      do_write(4'($urandom), ra, rl, 1'b1, $urandom_range(0, 2));
      do_read(4'($urandom), ra, rl, 2, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
